// File: rtl/dq_decode_pkg.sv
// Shared constants, operation encoding and buffered-entry layout for the DQ decode stage.
package dq_decode_pkg;

  localparam int unsigned INSTR_WIDTH  = 32;
  localparam int unsigned REG_WIDTH    = 5;
  localparam int unsigned OFFSET_WIDTH = 64;
  localparam int unsigned TAG_WIDTH    = 8;

  localparam logic [5:0] OPC_LQ     = 6'd56;
  localparam logic [5:0] OPC_DQ_VSX = 6'd61;
  localparam logic [2:0] XO_LXV     = 3'd1;
  localparam logic [2:0] XO_STXV    = 3'd5;

  typedef enum logic [1:0] {
    LQ   = 2'd0,
    LXV  = 2'd1,
    STXV = 2'd2
  } dq_op_t;

  typedef struct packed {
    dq_op_t                  op;
    logic [REG_WIDTH:0]      rt;
    logic [REG_WIDTH-1:0]    ra;
    logic [OFFSET_WIDTH-1:0] offset;
    logic                    illegal;
    logic [TAG_WIDTH-1:0]    tag;
  } dq_entry_t;

endpackage

// File: rtl/dq_decode_fifo.sv
// DEPTH-entry FIFO of decoded entries; the head is kept in its own register so it
// is zero after reset and holds the last presented entry once the FIFO drains.
module dq_decode_fifo
  import dq_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      push_i,
  input  dq_entry_t entry_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output dq_entry_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  dq_entry_t        mem_q [DEPTH];
  dq_entry_t        head_q, head_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_q, count_d;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;
  assign rd_next = rd_ptr_q + PTR_W'(1);

  // Next pointers, occupancy and head entry.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    head_d   = head_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_next;
    // The new entry becomes head when nothing else will be left in front of it.
    if (push_i && (empty_o || (pop_i && count_q == CNT_W'(1)))) begin
      head_d = entry_i;
    end else if (pop_i && count_q > CNT_W'(1)) begin
      head_d = mem_q[rd_next];
    end
  end

  // Control and head registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are only read once written, so it carries no reset.
  always_ff @(posedge clock_i) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/dq_decode_stage.sv
// Registered decode stage for DQ-form lq/lxv/stxv with valid/ready handshake,
// output buffer and saturating statistics.
module dq_decode_stage
  import dq_decode_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [INSTR_WIDTH-1:0]  instruction_i,
  input  logic [TAG_WIDTH-1:0]    tag_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [1:0]              op_o,
  output logic [REG_WIDTH:0]      rt_o,
  output logic [REG_WIDTH-1:0]    ra_o,
  output logic [OFFSET_WIDTH-1:0] offset_o,
  output logic                    illegal_o,
  output logic [TAG_WIDTH-1:0]    tag_o,
  output logic [COUNT_WIDTH-1:0]  decoded_count_o,
  output logic [COUNT_WIDTH-1:0]  illegal_count_o
);

  logic                   full, empty;
  logic                   accept, push, pop;
  logic                   is_dq;
  logic [5:0]             opcode;
  logic [2:0]             xo;
  logic [REG_WIDTH-1:0]   t_field;
  dq_entry_t              entry, head;
  logic [COUNT_WIDTH-1:0] decoded_q, decoded_d;
  logic [COUNT_WIDTH-1:0] illegal_q, illegal_d;

  // Instruction bit k (MSB-first numbering) is instruction_i[31-k].
  assign opcode  = instruction_i[31:26];
  assign t_field = instruction_i[25:21];
  assign xo      = instruction_i[2:0];

  assign ready_o = !full;
  assign accept  = valid_i && ready_o;
  assign push    = accept && is_dq;
  assign valid_o = !empty;
  assign pop     = valid_o && ready_i;

  // Field extraction and form classification of the incoming instruction.
  always_comb begin
    is_dq         = 1'b0;
    entry         = '0;
    entry.ra      = instruction_i[20:16];
    entry.offset  = {{(OFFSET_WIDTH-16){instruction_i[15]}}, instruction_i[15:4], 4'b0000};
    entry.tag     = tag_i;
    if (opcode == OPC_LQ) begin
      is_dq         = 1'b1;
      entry.op      = LQ;
      entry.rt      = {1'b0, t_field};
      entry.illegal = t_field[0] || (t_field == instruction_i[20:16]);
    end else if (opcode == OPC_DQ_VSX && xo == XO_LXV) begin
      is_dq    = 1'b1;
      entry.op = LXV;
      entry.rt = {instruction_i[3], t_field};
    end else if (opcode == OPC_DQ_VSX && xo == XO_STXV) begin
      is_dq    = 1'b1;
      entry.op = STXV;
      entry.rt = {instruction_i[3], t_field};
    end
  end

  dq_decode_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign op_o      = head.op;
  assign rt_o      = head.rt;
  assign ra_o      = head.ra;
  assign offset_o  = head.offset;
  assign illegal_o = head.illegal;
  assign tag_o     = head.tag;

  // Saturating push and illegal-push counters.
  always_comb begin
    decoded_d = decoded_q;
    illegal_d = illegal_q;
    if (push && decoded_q != '1) decoded_d = decoded_q + COUNT_WIDTH'(1);
    if (push && entry.illegal && illegal_q != '1) illegal_d = illegal_q + COUNT_WIDTH'(1);
  end

  // Counter registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      decoded_q <= '0;
      illegal_q <= '0;
    end else begin
      decoded_q <= decoded_d;
      illegal_q <= illegal_d;
    end
  end

  assign decoded_count_o = decoded_q;
  assign illegal_count_o = illegal_q;

endmodule
